// File: rtl/mux2a1_dosbits_arb.sv
// Two-lane 2-bit stream merger: per-lane FIFOs, one-grant-per-cycle arbiter, registered output.
// Define MUX2A1_ROUND_ROBIN_EN for round-robin contention; fixed priority (lane 0) otherwise.

module mux2a1_dosbits_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  output logic [1:0] head,
  output logic       full,
  output logic       empty,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  push_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign err   = err_q;

  always_comb begin
    // A pop on the same edge frees the slot, so a full lane can still accept.
    push_ok  = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (push & ~push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

module mux2a1_dosbits_arb #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid0,
  input  logic [1:0] data_in0,
  input  logic       valid1,
  input  logic [1:0] data_in1,
  input  logic       pause,
  output logic       valid_out,
  output logic [1:0] data_out,
  output logic       selector_out,
  output logic       full0,
  output logic       full1,
  output logic       empty0,
  output logic       empty1,
  output logic       err0,
  output logic       err1
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]      vld_in, full_w, empty_w, err_w, pop_w, elig;
  logic [NUM_LANES-1:0][1:0] din_w, head_w;
  logic                      gnt_any, gnt_lane;
  logic                      valid_out_q, valid_out_d;
  logic [1:0]                data_out_q, data_out_d;
  logic                      sel_q, sel_d;
  logic                      last_q, last_d;

  assign vld_in = {valid1, valid0};
  assign din_w  = {data_in1, data_in0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mux2a1_dosbits_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (vld_in[g]),
      .din   (din_w[g]),
      .pop   (pop_w[g]),
      .head  (head_w[g]),
      .full  (full_w[g]),
      .empty (empty_w[g]),
      .err   (err_w[g])
    );
  end

  always_comb begin
    elig    = ~empty_w & {NUM_LANES{~pause}};
    gnt_any = |elig;
`ifdef MUX2A1_ROUND_ROBIN_EN
    gnt_lane = (&elig) ? ~last_q : elig[1];
`else
    gnt_lane = ~elig[0];
`endif
    pop_w       = gnt_any ? (gnt_lane ? 2'b10 : 2'b01) : 2'b00;
    valid_out_d = gnt_any;
    data_out_d  = gnt_any ? head_w[gnt_lane] : 2'b00;
    sel_d       = gnt_any & gnt_lane;
    last_d      = gnt_any ? gnt_lane : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_q <= 1'b0;
      data_out_q  <= 2'b00;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign selector_out = sel_q;
  assign {full1, full0}   = full_w;
  assign {empty1, empty0} = empty_w;
  assign {err1, err0}     = err_w;
endmodule
